// File: rtl/decoder_addr_seq.sv
// decoder_addr_seq: prescaled 3-bit address sequencer feeding a 3-to-8 decoder.
// A prescaler divides the clock into step ticks. On each tick the address
// counts up, counts down, ping-pongs or holds, depending on mode. A parallel
// load overrides the step and restarts the prescaler. step_pulse and wrap are
// registered single-cycle strobes that line up with the new address value.
module decoder_addr_seq #(
    parameter int TICK_DIV = 4,
    parameter int DIV_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       load,
    input  logic [2:0] load_addr,
    output logic [2:0] address,
    output logic       dir,
    output logic       step_pulse,
    output logic       wrap
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_PING = 2'b11;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       address_q, address_d;
    logic             dir_q, dir_d;
    logic             step_pulse_q, step_pulse_d;
    logic             wrap_q, wrap_d;
    logic             tick;

    // Prescaler tick: fires on the last count of an enabled period
    always_comb begin
        tick = en && (div_cnt_q == DIV_LAST);
    end

    // Prescaler next value: load restarts the period, en low freezes it
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (load) begin
            div_cnt_d = '0;
        end else if (en) begin
            if (tick) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    // Address, direction and strobe next values; load beats a coincident tick
    always_comb begin
        address_d    = address_q;
        dir_d        = dir_q;
        step_pulse_d = 1'b0;
        wrap_d       = 1'b0;
        if (load) begin
            address_d = load_addr;
        end else if (tick) begin
            case (mode)
                MODE_UP: begin
                    address_d    = address_q + 3'd1;
                    dir_d        = 1'b0;
                    step_pulse_d = 1'b1;
                    wrap_d       = (address_q == 3'd7);
                end
                MODE_DOWN: begin
                    address_d    = address_q - 3'd1;
                    dir_d        = 1'b1;
                    step_pulse_d = 1'b1;
                    wrap_d       = (address_q == 3'd0);
                end
                MODE_PING: begin
                    step_pulse_d = 1'b1;
                    if (!dir_q) begin
                        if (address_q == 3'd7) begin
                            address_d = 3'd6;
                            dir_d     = 1'b1;
                            wrap_d    = 1'b1;
                        end else begin
                            address_d = address_q + 3'd1;
                        end
                    end else begin
                        if (address_q == 3'd0) begin
                            address_d = 3'd1;
                            dir_d     = 1'b0;
                            wrap_d    = 1'b1;
                        end else begin
                            address_d = address_q - 3'd1;
                        end
                    end
                end
                MODE_HOLD: begin
                    address_d = address_q;
                end
                default: begin
                    address_d = address_q;
                end
            endcase
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            address_q    <= 3'd0;
            dir_q        <= 1'b0;
            step_pulse_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            address_q    <= address_d;
            dir_q        <= dir_d;
            step_pulse_q <= step_pulse_d;
            wrap_q       <= wrap_d;
        end
    end

    assign address    = address_q;
    assign dir        = dir_q;
    assign step_pulse = step_pulse_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_decoder_addr_seq.sv
// tb_decoder_addr_seq: directed bench for decoder_addr_seq.
// Two instances share the inputs: one with TICK_DIV=4 for the main scans,
// one with TICK_DIV=1 for the step-every-cycle case after a mid-scan reset.
module tb_decoder_addr_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [2:0] load_addr;

    logic [2:0] address, address1;
    logic       dir, dir1;
    logic       step_pulse, step_pulse1;
    logic       wrap, wrap1;

    int testsRun = 0;
    int testsFailed = 0;
    int pp [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1};

    decoder_addr_seq #(.TICK_DIV(4), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .load_addr(load_addr), .address(address), .dir(dir),
        .step_pulse(step_pulse), .wrap(wrap)
    );

    decoder_addr_seq #(.TICK_DIV(1), .DIV_W(16)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .load_addr(load_addr), .address(address1), .dir(dir1),
        .step_pulse(step_pulse1), .wrap(wrap1)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                                 input logic l, input logic [2:0] la);
        rst = r; en = e; mode = m; load = l; load_addr = la;
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic tickClk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag,
                               input logic [2:0] oA, input logic oD, input logic oS, input logic oW,
                               input logic [2:0] eA, input logic eD, input logic eS, input logic eW);
        testsRun++;
        assert (oA === eA) else begin
            testsFailed++;
            $error("[TB] FAIL %s address observed %0d expected %0d", tag, oA, eA);
        end
        testsRun++;
        assert (oD === eD) else begin
            testsFailed++;
            $error("[TB] FAIL %s dir observed %0b expected %0b", tag, oD, eD);
        end
        testsRun++;
        assert (oS === eS) else begin
            testsFailed++;
            $error("[TB] FAIL %s step_pulse observed %0b expected %0b", tag, oS, eS);
        end
        testsRun++;
        assert (oW === eW) else begin
            testsFailed++;
            $error("[TB] FAIL %s wrap observed %0b expected %0b", tag, oW, eW);
        end
    endtask

    initial begin
        int k;
        logic [2:0] eA;
        logic eD;

        // Reset then count up: a step every 4 edges, wrap on 7->0 at edge 32
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 3'd0);
        tickClk(1);
        checkOutput("reset", address, dir, step_pulse, wrap, 3'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset1", address1, dir1, step_pulse1, wrap1, 3'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'd0);
        for (int e = 1; e <= 32; e++) begin
            tickClk(1);
            checkOutput("up", address, dir, step_pulse, wrap,
                        3'((e / 4) % 8), 1'b0, (e % 4) == 0, e == 32);
        end

        // Count down from reset: 0->7 with wrap, then 6, 5
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 3'd0);
        tickClk(1);
        checkOutput("reset_dn", address, dir, step_pulse, wrap, 3'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 3'd0);
        for (int e = 1; e <= 12; e++) begin
            tickClk(1);
            k = e / 4;
            checkOutput("down", address, dir, step_pulse, wrap,
                        3'((8 - k) % 8), k > 0, (e % 4) == 0, e == 4);
        end

        // Ping-pong 28 steps from 0: wrap and dir flip only at the ends
        applyStimulus(1'b1, 1'b1, 2'b11, 1'b0, 3'd0);
        tickClk(1);
        applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 3'd0);
        for (int e = 1; e <= 112; e++) begin
            tickClk(1);
            k = e / 4;
            eA = 3'(pp[k % 14]);
            if (k == 0) eD = 1'b0;
            else if ((k % 14) >= 1 && (k % 14) <= 7) eD = 1'b0;
            else eD = 1'b1;
            checkOutput("ping", address, dir, step_pulse, wrap, eA, eD, (e % 4) == 0,
                        ((e % 4) == 0) && (((k % 14) == 8) || ((k % 14) == 1 && k > 1)));
        end

        // Load collides with the tick at edge 4; next step 4 edges later
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 3'd0);
        tickClk(1);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'd0);
        tickClk(3);
        checkOutput("pre_load", address, dir, step_pulse, wrap, 3'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 3'd5);
        tickClk(1);
        checkOutput("load", address, dir, step_pulse, wrap, 3'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'd0);
        for (int e = 1; e <= 3; e++) begin
            tickClk(1);
            checkOutput("post_load", address, dir, step_pulse, wrap, 3'd5, 1'b0, 1'b0, 1'b0);
        end
        tickClk(1);
        checkOutput("load_step", address, dir, step_pulse, wrap, 3'd6, 1'b0, 1'b1, 1'b0);

        // Enable gating: 3 frozen cycles delay the next step by 3
        tickClk(2);
        applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 3'd0);
        for (int e = 1; e <= 3; e++) begin
            tickClk(1);
            checkOutput("en_low", address, dir, step_pulse, wrap, 3'd6, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'd0);
        tickClk(1);
        checkOutput("en_pre", address, dir, step_pulse, wrap, 3'd6, 1'b0, 1'b0, 1'b0);
        tickClk(1);
        checkOutput("en_step", address, dir, step_pulse, wrap, 3'd7, 1'b0, 1'b1, 1'b0);

        // Hold mode for 20 cycles: nothing moves
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 3'd0);
        for (int e = 1; e <= 20; e++) begin
            tickClk(1);
            checkOutput("hold", address, dir, step_pulse, wrap, 3'd7, 1'b0, 1'b0, 1'b0);
        end

        // Reset mid-scan at address 6 / dir 1, with a competing load
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 3'd0);
        tickClk(1);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 3'd0);
        tickClk(8);
        checkOutput("pre_rst", address, dir, step_pulse, wrap, 3'd6, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b11, 1'b1, 3'd3);
        tickClk(1);
        checkOutput("mid_rst", address, dir, step_pulse, wrap, 3'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_rst1", address1, dir1, step_pulse1, wrap1, 3'd0, 1'b0, 1'b0, 1'b0);

        // TICK_DIV=1 instance steps on every enabled cycle
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 3'd0);
        for (int e = 1; e <= 10; e++) begin
            tickClk(1);
            checkOutput("div1", address1, dir1, step_pulse1, wrap1,
                        3'(e % 8), 1'b0, 1'b1, e == 8);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
